// File: rtl/cla_share_arb.sv
// Round-robin share of one pipelined CLA adder among NREQ requesters, with tag-tracked response steering.
// Latency: grant/operand mux is combinational; response appears LAT cycles after the issue cycle.
// Backpressure: req_ready withheld under stall/reset; no response backpressure (rsp_valid is a one-cycle pulse).
module cla_share_arb #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int LAT   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    stall,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    input  logic [NREQ-1:0]         req_cin,
    output logic [NREQ-1:0]         req_ready,
    output logic [WIDTH-1:0]        add_a,
    output logic [WIDTH-1:0]        add_b,
    output logic                    add_cin,
    input  logic [WIDTH-1:0]        add_sum,
    input  logic                    add_cout,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [WIDTH-1:0]        rsp_sum,
    output logic                    rsp_cout,
    output logic [2:0]              rsp_id,
    output logic [15:0]             issued_cnt
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   ptr;
    logic [NREQ-1:0] rot_vld;
    logic            gnt_vld;
    logic [2:0]      gnt_id;
    logic            tag_vld [LAT];
    logic [2:0]      tag_id  [LAT];

    // Round-robin search: rotate the request vector so ptr lands at bit 0, take the first set bit.
    always_comb begin
        rot_vld = NREQ'({req_valid, req_valid} >> ptr);
        gnt_vld = 1'b0;
        gnt_id  = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (!gnt_vld && rot_vld[j] && rst_n && !stall) begin
                gnt_vld = 1'b1;
                gnt_id  = 3'((int'(ptr) + j) % NREQ);
            end
        end
    end

    // One-hot ready plus operand mux; idle adder inputs are forced to zero.
    always_comb begin
        req_ready = '0;
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_vld && gnt_id == 3'(i)) begin
                req_ready[i] = 1'b1;
                add_a        = req_a[i*WIDTH +: WIDTH];
                add_b        = req_b[i*WIDTH +: WIDTH];
                add_cin      = req_cin[i];
            end
        end
    end

    // Pointer advances past the winner on every issue; issue counter saturates.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr        <= '0;
            issued_cnt <= '0;
        end else if (gnt_vld) begin
            ptr <= PW'((int'(gnt_id) + 1) % NREQ);
            if (issued_cnt != 16'hFFFF) begin
                issued_cnt <= issued_cnt + 16'd1;
            end
        end
    end

    // Tag pipeline mirrors the adder depth; it shifts every cycle, stall only gates new issues.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < LAT; s++) begin
                tag_vld[s] <= 1'b0;
                tag_id[s]  <= '0;
            end
        end else begin
            tag_vld[0] <= gnt_vld;
            tag_id[0]  <= gnt_id;
            for (int s = 1; s < LAT; s++) begin
                tag_vld[s] <= tag_vld[s-1];
                tag_id[s]  <= tag_id[s-1];
            end
        end
    end

    // Steer the returning result to the requester named by the oldest tag.
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid[i] = tag_vld[LAT-1] && (tag_id[LAT-1] == 3'(i));
        end
        rsp_id   = tag_id[LAT-1];
        rsp_sum  = add_sum;
        rsp_cout = add_cout;
    end

endmodule

// File: doc/cla_share_arb.md
# cla_share_arb

Round-robin arbiter that shares one pipelined 32-bit carry-lookahead adder between `NREQ` requesters. Each requester presents operands with a valid/ready handshake. The arbiter issues at most one operation per cycle into the adder and tracks the granted requester ID through a tag pipeline matched to the adder latency. It then steers the returning sum and carry-out back to the issuing requester as a one-cycle response pulse. The block sits between client logic and the registered CLA datapath; it contains no arithmetic itself.

## Interface
Parameters:
- `NREQ`, 4 — number of requesters, 2..8.
- `WIDTH`, 32 — operand and sum width.
- `LAT`, 2 — adder latency in cycles from issue cycle to the cycle where the sum is valid; must be ≥1.

Ports:
- `clk` input 1 — single clock, rising edge.
- `rst_n` input 1 — synchronous, active-low reset.
- `stall` input 1 — when high, no new issue; in-flight ops still complete.
- `req_valid` input NREQ — per-requester request.
- `req_a` input NREQ*WIDTH — operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_b` input NREQ*WIDTH — operand B, packed the same way as `req_a`.
- `req_cin` input NREQ — per-requester carry-in.
- `req_ready` output NREQ — one-hot grant; handshake completes when `req_valid[i] & req_ready[i]`.
- `add_a` output WIDTH — muxed operand A to the adder.
- `add_b` output WIDTH — muxed operand B to the adder.
- `add_cin` output 1 — muxed carry-in to the adder.
- `add_sum` input WIDTH — adder result.
- `add_cout` input 1 — adder carry-out.
- `rsp_valid` output NREQ — one-hot response pulse.
- `rsp_sum` output WIDTH — `add_sum` passthrough.
- `rsp_cout` output 1 — `add_cout` passthrough.
- `rsp_id` output 3 — index of the responding requester.
- `issued_cnt` output 16 — count of completed handshakes, saturating at 0xFFFF.

## Operation
- Round-robin pointer `ptr` (log2 NREQ bits):
  - Grant goes to the first i with `req_valid[i]` high, searching `ptr`, `ptr+1`, … modulo NREQ.
  - On issue, `ptr` is set to granted ID + 1, wrapping NREQ-1 → 0.
  - No issue means `ptr` holds.
- `req_ready` is combinational from `req_valid`, `ptr` and `stall`:
  - At most one bit is high.
  - All bits are zero when `stall=1`, when `rst_n=0`, or when no request is valid.
- `add_a`, `add_b` and `add_cin` are combinational muxes of the granted requester's operands. They are zero when there is no grant, so the adder computes 0+0+0.
- Tag pipeline: LAT stages of {valid, id}.
  - Stage 0 loads {issue, grant_id} at the clock edge ending the issue cycle.
  - Each stage shifts every cycle regardless of `stall`.
  - The response is taken from stage LAT-1.
- Response, driven combinationally from the last tag stage and adder inputs:
  - `rsp_valid[id] = tag_valid`.
  - `rsp_id = tag_id`.
  - `rsp_sum = add_sum`, `rsp_cout = add_cout`; both are passthrough regardless of tag valid.
- There is no response backpressure: clients must accept `rsp_valid` in the cycle it is high.
- `issued_cnt` increments by 1 per issue and saturates at 0xFFFF.
- Requester i must hold its operands stable while `req_valid[i]=1 & req_ready[i]=0`.
- Once a requester's `req_valid` is high, it is granted within NREQ issuing cycles.

## Timing
- Issue in cycle k → `rsp_valid` high in cycle k+LAT for exactly one cycle.
- Throughput is one op per cycle. Back-to-back issues give back-to-back responses in issue order.
- Reset values, with `rst_n=0` sampled at a rising edge:
  - `ptr=0`, all tag valids 0, `issued_cnt=0`.
  - Hence `req_ready=0`, `rsp_valid=0` and `rsp_id=0` from the next cycle.
  - `req_ready` is additionally forced to 0 combinationally while `rst_n=0`.
  - Operand outputs are 0 while `rst_n=0`.
- Reset mid-operation:
  - In-flight tags are cleared, so adder results returning in the following LAT cycles produce no `rsp_valid`.
  - The first issue after reset goes to the lowest-index valid requester.
- Stall asserted in the same cycle as `req_valid` means no handshake. Ops already in flight still respond on schedule.
- A single requester valid every cycle is granted every cycle; `ptr` wraps past it harmlessly.
- All requesters valid continuously are served in order 0,1,…,NREQ-1,0,…, one per cycle.

## Test plan
1. **Single requester.** Reset; raise `req_valid[2]` for one handshake with A=0xFFFFFFFF, B=0x00000001, cin=0. Required: `req_ready=0100b` in the same cycle; 2 cycles later (LAT=2) `rsp_valid=0100b`, `rsp_id=2`, `rsp_sum=0x00000000`, `rsp_cout=1`; `issued_cnt=1`.
2. **All requesters contending.** Requesters 0–3 hold valid with A=i, B=0x10, cin=1. Required: grants 0,1,2,3,0 on consecutive cycles; responses arrive LAT cycles later in the same order with sums 0x11, 0x12, 0x13, 0x14.
3. **Stall.** Assert `stall` for 3 cycles while requesters 1 and 3 are valid, with one op from requester 0 already in flight. Required: `req_ready=0` throughout; requester 0's response still arrives on time; after stall drops, requester 1 is granted first.
4. **Reset mid-flight.** Issue 2 ops on consecutive cycles, then pull `rst_n` low for one edge before either response. Required: no `rsp_valid` in the following 3 cycles, `issued_cnt=0`, `ptr` back at 0.
5. **Saturation.** Preload by issuing 65535 ops, then 2 more. Required: `issued_cnt` stays at 0xFFFF; responses are unaffected.
6. **Fairness under late arrival.** Requester 3 is always valid; requester 1 becomes valid mid-stream. Required: requester 1 is granted within 4 cycles, and grants then alternate 1,3,1,3.
